// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART byte-framing layer.
// HEADER doubles as the escape byte and the command introducer.
package uart_pkg;

    localparam logic [7:0] HEADER = 8'h01;

    typedef enum logic {
        RX_IDLE,
        RX_ESC
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_FIRST,
        TX_SECOND
    } tx_state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible without a read.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    logic w_doPop;
    logic w_doPush;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
    end

endmodule

// File: rtl/uart_frame_codec.sv
// Byte framing between the UART PHY and the DMI TAP: un-escapes and tags received
// bytes into a FWFT FIFO, and escapes/prefixes outgoing TAP bytes for the transmitter.
module uart_frame_codec
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RX_VALID_I,
    input  logic [7:0] RX_DATA_I,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       CMD_REC_O,
    output logic       RX_EMPTY_O,
    output logic       RX_OVERFLOW_O,
    input  logic       WRITE_I,
    input  logic [7:0] DATA_SEND_I,
    input  logic       SEND_COMMAND_I,
    input  logic [7:0] COMMAND_I,
    output logic       TX_READY_O,
    output logic       TX_VALID_O,
    output logic [7:0] TX_DATA_O,
    input  logic       TX_READY_I
);

    rx_state_t r_rxState;
    rx_state_t w_rxNext;
    logic      w_push;
    logic [8:0] w_pushEntry;
    logic [8:0] w_head;
    logic      w_full;
    logic      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_rxCount;
    logic      w_popOk;
    logic      r_rxOverflow;

    tx_state_t r_txState;
    tx_state_t w_txNext;
    logic      r_txValid;
    logic      w_txNextValid;
    logic [7:0] r_txData;
    logic [7:0] w_txNextData;
    logic [7:0] r_txSecond;
    logic [7:0] w_txNextSecond;
    logic      r_txTwo;
    logic      w_txNextTwo;

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_rxState <= RX_IDLE;
        else       r_rxState <= w_rxNext;
    end

    // A doubled HEADER is literal data; HEADER followed by anything else is a command.
    always_comb begin
        w_rxNext    = r_rxState;
        w_push      = 1'b0;
        w_pushEntry = '0;
        if (RX_VALID_I) begin
            case (r_rxState)
                RX_IDLE: begin
                    if (RX_DATA_I == HEADER) begin
                        w_rxNext = RX_ESC;
                    end else begin
                        w_push      = 1'b1;
                        w_pushEntry = {1'b0, RX_DATA_I};
                    end
                end
                RX_ESC: begin
                    w_rxNext    = RX_IDLE;
                    w_push      = 1'b1;
                    w_pushEntry = (RX_DATA_I == HEADER) ? {1'b0, HEADER} : {1'b1, RX_DATA_I};
                end
                default: w_rxNext = RX_IDLE;
            endcase
        end
    end

    uart_cmd_fifo #(
        .WIDTH(9),
        .DEPTH(FIFO_DEPTH)
    ) u_rxFifo (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (READ_I),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_rxCount)
    );

    assign w_popOk    = READ_I & ~w_empty;
    assign RX_EMPTY_O = w_empty;
    assign DATA_REC_O = (w_rxCount != '0) ? w_head[7:0] : 8'h00;
    assign CMD_REC_O  = (w_rxCount != '0) & w_head[8];

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_rxOverflow <= 1'b0;
        else       r_rxOverflow <= w_push & w_full & ~w_popOk;
    end

    assign RX_OVERFLOW_O = r_rxOverflow;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_txState  <= TX_IDLE;
            r_txValid  <= 1'b0;
            r_txData   <= 8'h00;
            r_txSecond <= 8'h00;
            r_txTwo    <= 1'b0;
        end else begin
            r_txState  <= w_txNext;
            r_txValid  <= w_txNextValid;
            r_txData   <= w_txNextData;
            r_txSecond <= w_txNextSecond;
            r_txTwo    <= w_txNextTwo;
        end
    end

    // The whole sequence is decided at acceptance; later TAP input changes are ignored.
    always_comb begin
        w_txNext       = r_txState;
        w_txNextValid  = r_txValid;
        w_txNextData   = r_txData;
        w_txNextSecond = r_txSecond;
        w_txNextTwo    = r_txTwo;
        case (r_txState)
            TX_IDLE: begin
                if (WRITE_I) begin
                    w_txNext      = TX_FIRST;
                    w_txNextValid = 1'b1;
                    if (SEND_COMMAND_I) begin
                        w_txNextData   = HEADER;
                        w_txNextSecond = COMMAND_I;
                        w_txNextTwo    = 1'b1;
                    end else if (DATA_SEND_I == HEADER) begin
                        w_txNextData   = HEADER;
                        w_txNextSecond = HEADER;
                        w_txNextTwo    = 1'b1;
                    end else begin
                        w_txNextData   = DATA_SEND_I;
                        w_txNextSecond = 8'h00;
                        w_txNextTwo    = 1'b0;
                    end
                end
            end
            TX_FIRST: begin
                if (TX_READY_I) begin
                    if (r_txTwo) begin
                        w_txNext     = TX_SECOND;
                        w_txNextData = r_txSecond;
                    end else begin
                        w_txNext      = TX_IDLE;
                        w_txNextValid = 1'b0;
                        w_txNextData  = 8'h00;
                    end
                end
            end
            TX_SECOND: begin
                if (TX_READY_I) begin
                    w_txNext      = TX_IDLE;
                    w_txNextValid = 1'b0;
                    w_txNextData  = 8'h00;
                    w_txNextTwo   = 1'b0;
                end
            end
            default: begin
                w_txNext      = TX_IDLE;
                w_txNextValid = 1'b0;
                w_txNextData  = 8'h00;
                w_txNextTwo   = 1'b0;
            end
        endcase
    end

    assign TX_READY_O = (r_txState == TX_IDLE);
    assign TX_VALID_O = r_txValid;
    assign TX_DATA_O  = r_txData;

endmodule

// File: tb/tb_uart_frame_codec.sv
// Directed bench for uart_frame_codec; expected RX entries and TX bytes are queued
// when stimulus is applied and compared as the DUT presents them.
module tb_uart_frame_codec;
    import uart_pkg::*;

    localparam int FIFO_DEPTH = 8;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       RX_VALID_I = 1'b0;
    logic [7:0] RX_DATA_I = 8'h00;
    logic       READ_I = 1'b0;
    logic [7:0] DATA_REC_O;
    logic       CMD_REC_O;
    logic       RX_EMPTY_O;
    logic       RX_OVERFLOW_O;
    logic       WRITE_I = 1'b0;
    logic [7:0] DATA_SEND_I = 8'h00;
    logic       SEND_COMMAND_I = 1'b0;
    logic [7:0] COMMAND_I = 8'h00;
    logic       TX_READY_O;
    logic       TX_VALID_O;
    logic [7:0] TX_DATA_O;
    logic       TX_READY_I = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] rxQ[$];
    logic [7:0] txQ[$];
    int txCycles;

    uart_frame_codec #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK_I          (CLK_I),
        .RST_I          (RST_I),
        .RX_VALID_I     (RX_VALID_I),
        .RX_DATA_I      (RX_DATA_I),
        .READ_I         (READ_I),
        .DATA_REC_O     (DATA_REC_O),
        .CMD_REC_O      (CMD_REC_O),
        .RX_EMPTY_O     (RX_EMPTY_O),
        .RX_OVERFLOW_O  (RX_OVERFLOW_O),
        .WRITE_I        (WRITE_I),
        .DATA_SEND_I    (DATA_SEND_I),
        .SEND_COMMAND_I (SEND_COMMAND_I),
        .COMMAND_I      (COMMAND_I),
        .TX_READY_O     (TX_READY_O),
        .TX_VALID_O     (TX_VALID_O),
        .TX_DATA_O      (TX_DATA_O),
        .TX_READY_I     (TX_READY_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " DATA_REC_O"},    16'(DATA_REC_O),    16'h0000);
        checkOutput({tag, " CMD_REC_O"},     16'(CMD_REC_O),     16'h0000);
        checkOutput({tag, " RX_EMPTY_O"},    16'(RX_EMPTY_O),    16'h0001);
        checkOutput({tag, " RX_OVERFLOW_O"}, 16'(RX_OVERFLOW_O), 16'h0000);
        checkOutput({tag, " TX_READY_O"},    16'(TX_READY_O),    16'h0001);
        checkOutput({tag, " TX_VALID_O"},    16'(TX_VALID_O),    16'h0000);
        checkOutput({tag, " TX_DATA_O"},     16'(TX_DATA_O),     16'h0000);
    endtask

    task automatic applyStimulus(input logic [7:0] rxByte);
        RX_VALID_I = 1'b1;
        RX_DATA_I  = rxByte;
        tick();
        RX_VALID_I = 1'b0;
        RX_DATA_I  = 8'h00;
    endtask

    // Pops every queued entry through READ_I and then requires the FIFO to be empty.
    task automatic drainRx(input string tag);
        logic [8:0] expEntry;
        while (rxQ.size() > 0) begin
            expEntry = rxQ.pop_front();
            checkOutput({tag, " head"}, 16'({RX_EMPTY_O, CMD_REC_O, DATA_REC_O}), 16'({1'b0, expEntry}));
            READ_I = 1'b1;
            tick();
            READ_I = 1'b0;
        end
        checkOutput({tag, " empty after drain"}, 16'(RX_EMPTY_O), 16'h0001);
    endtask

    task automatic writeTx(input string tag, input logic cmdFlag, input logic [7:0] cmd, input logic [7:0] data);
        checkOutput({tag, " ready before write"}, 16'(TX_READY_O), 16'h0001);
        WRITE_I        = 1'b1;
        SEND_COMMAND_I = cmdFlag;
        COMMAND_I      = cmd;
        DATA_SEND_I    = data;
        tick();
        WRITE_I        = 1'b0;
        SEND_COMMAND_I = 1'b0;
        COMMAND_I      = 8'h00;
        DATA_SEND_I    = 8'h00;
        checkOutput({tag, " busy after accept"},  16'(TX_READY_O), 16'h0000);
        checkOutput({tag, " valid after accept"}, 16'(TX_VALID_O), 16'h0001);
    endtask

    // Consumes the TX stream against txQ; a byte left waiting must stay valid and unchanged.
    task automatic runTx(input string tag, input logic randomReady, output int cycles);
        int c = 0;
        logic holdValid = 1'b0;
        logic [7:0] holdData = 8'h00;
        while (txQ.size() > 0 && c < 200) begin
            if (holdValid) begin
                checkOutput({tag, " hold valid"}, 16'(TX_VALID_O), 16'h0001);
                checkOutput({tag, " hold data"},  16'(TX_DATA_O),  16'(holdData));
            end
            TX_READY_I = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (TX_VALID_O && TX_READY_I) begin
                checkOutput({tag, " byte"}, 16'(TX_DATA_O), 16'(txQ.pop_front()));
                holdValid = 1'b0;
            end else begin
                holdValid = TX_VALID_O;
                holdData  = TX_DATA_O;
            end
            tick();
            c++;
        end
        TX_READY_I = 1'b0;
        checkOutput({tag, " bytes outstanding"}, 16'(txQ.size()), 16'h0000);
        checkOutput({tag, " ready after last"},  16'(TX_READY_O), 16'h0001);
        checkOutput({tag, " valid after last"},  16'(TX_VALID_O), 16'h0000);
        cycles = c;
    endtask

    initial begin
        tick();
        tick();
        RST_I = 1'b0;
        checkResetValues("reset");

        // Plain data, then HEADER-escaped command.
        applyStimulus(8'h41);
        rxQ.push_back({1'b0, 8'h41});
        checkOutput("rx empty falls", 16'(RX_EMPTY_O), 16'h0000);
        applyStimulus(HEADER);
        applyStimulus(8'h05);
        rxQ.push_back({1'b1, 8'h05});
        drainRx("rx cmd");

        // Doubled HEADER is literal data.
        applyStimulus(HEADER);
        applyStimulus(HEADER);
        rxQ.push_back({1'b0, 8'h01});
        applyStimulus(8'h7F);
        rxQ.push_back({1'b0, 8'h7F});
        drainRx("rx escaped");

        // Fill to capacity, then overflow by one.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            applyStimulus(8'(8'h10 + i));
            rxQ.push_back({1'b0, 8'(8'h10 + i)});
        end
        checkOutput("no overflow at full", 16'(RX_OVERFLOW_O), 16'h0000);
        applyStimulus(8'h18);
        checkOutput("overflow pulse", 16'(RX_OVERFLOW_O), 16'h0001);
        tick();
        checkOutput("overflow one cycle", 16'(RX_OVERFLOW_O), 16'h0000);

        // Simultaneous push and pop while full keeps the count at capacity.
        checkOutput("full head", 16'({RX_EMPTY_O, CMD_REC_O, DATA_REC_O}), 16'({1'b0, rxQ.pop_front()}));
        RX_VALID_I = 1'b1;
        RX_DATA_I  = 8'h20;
        READ_I     = 1'b1;
        tick();
        RX_VALID_I = 1'b0;
        RX_DATA_I  = 8'h00;
        READ_I     = 1'b0;
        rxQ.push_back({1'b0, 8'h20});
        checkOutput("no overflow on push+pop", 16'(RX_OVERFLOW_O), 16'h0000);
        drainRx("rx full");

        // Command frame with a randomly stalling transmitter.
        txQ.push_back(HEADER);
        txQ.push_back(8'h23);
        writeTx("tx cmd", 1'b1, 8'h23, 8'h77);
        runTx("tx cmd", 1'b1, txCycles);

        // Escaped HEADER data followed by plain data at full rate.
        txQ.push_back(HEADER);
        txQ.push_back(HEADER);
        writeTx("tx esc", 1'b0, 8'h00, HEADER);
        runTx("tx esc", 1'b0, txCycles);
        checkOutput("tx esc cycles", 16'(txCycles), 16'd2);
        txQ.push_back(8'h55);
        writeTx("tx plain", 1'b0, 8'h00, 8'h55);
        runTx("tx plain", 1'b0, txCycles);
        checkOutput("tx plain cycles", 16'(txCycles), 16'd1);

        // Reset mid-frame on both paths.
        applyStimulus(8'h41);
        applyStimulus(HEADER);
        writeTx("tx abort", 1'b1, 8'h33, 8'h00);
        checkOutput("tx abort first", 16'(TX_DATA_O), 16'(HEADER));
        TX_READY_I = 1'b1;
        tick();
        TX_READY_I = 1'b0;
        checkOutput("tx abort second", 16'(TX_DATA_O), 16'h0033);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        checkResetValues("mid reset");
        applyStimulus(8'h05);
        rxQ.push_back({1'b0, 8'h05});
        drainRx("rx after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_frame_codec.md
# uart_frame_codec

Byte-framing layer between the UART PHY (receiver/transmitter) and the DMI UART TAP. On the receive side it removes escape framing, tags command bytes and buffers decoded bytes in a first-word-fall-through FIFO that the TAP drains. On the transmit side it frames TAP output (command header, data escaping) into a byte stream for the UART transmitter. One clock domain; the PHY and the TAP both run on CLK_I.

## Interface
- FIFO_DEPTH, 8, receive FIFO entries; power of two, ≥2.
- HEADER, 8'h01 (from uart_pkg), escape/command-introducer byte.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous, active-high reset.
- RX_VALID_I  in  1  one-cycle strobe from UART receiver; byte on RX_DATA_I. No backpressure.
- RX_DATA_I  in  8  received byte.
- READ_I  in  1  TAP pops FIFO head.
- DATA_REC_O  out  8  FIFO head byte; 0 when empty.
- CMD_REC_O  out  1  FIFO head is a command byte; 0 when empty.
- RX_EMPTY_O  out  1  FIFO empty.
- RX_OVERFLOW_O  out  1  one-cycle pulse; decoded byte dropped because FIFO full.
- WRITE_I  in  1  TAP requests a transmit; accepted only while TX_READY_O=1.
- DATA_SEND_I  in  8  data byte to send.
- SEND_COMMAND_I  in  1  send COMMAND_I as a command instead of data.
- COMMAND_I  in  8  command byte.
- TX_READY_O  out  1  framer idle, can accept WRITE_I.
- TX_VALID_O  out  1  byte on TX_DATA_O valid for UART transmitter.
- TX_DATA_O  out  8  byte to transmit.
- TX_READY_I  in  1  UART transmitter accepts byte (handshake when TX_VALID_O & TX_READY_I).

## Operation
- RX decoder FSM, states RX_IDLE and RX_ESC; reset to RX_IDLE; advances only on RX_VALID_I.
  - RX_IDLE: byte==HEADER → RX_ESC, no push; else push {cmd=0, byte}.
  - RX_ESC: byte==HEADER → push {0, HEADER}; else push {1, byte}; both return to RX_IDLE.
- FIFO: 9-bit entries {cmd, byte}; FWFT. READ_I with RX_EMPTY_O=1 is ignored.
  - Push while full and no pop: entry dropped, RX_OVERFLOW_O pulses, decoder state still advances.
  - Push and pop in the same cycle, including when full: both take effect; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- TX framer FSM, states TX_IDLE, TX_FIRST, TX_SECOND; reset to TX_IDLE.
  - TX_IDLE & WRITE_I, with TX_READY_O=1, latches the request and the sequence is chosen:
    - SEND_COMMAND_I=1: HEADER, then COMMAND_I. DATA_SEND_I is ignored.
    - Data equal to HEADER: HEADER, then HEADER.
    - Other data: single byte DATA_SEND_I.
  - TX_FIRST holds byte 1. On handshake it moves to TX_SECOND if two bytes are pending, else to TX_IDLE.
  - TX_SECOND holds byte 2. On handshake it moves to TX_IDLE.
- Reset at any time, including mid-frame: FIFO emptied, RX_ESC state discarded, pending TX sequence abandoned.
- Reset values: DATA_REC_O=0, CMD_REC_O=0, RX_EMPTY_O=1, RX_OVERFLOW_O=0, TX_READY_O=1, TX_VALID_O=0, TX_DATA_O=0.

## Timing
- RX_VALID_I in cycle n (push case) → entry visible and RX_EMPTY_O=0 in cycle n+1.
- READ_I in cycle n → next head, or RX_EMPTY_O=1, in cycle n+1.
- RX_OVERFLOW_O is asserted in cycle n+1 for a drop caused by RX_VALID_I in cycle n.
- WRITE_I accepted in cycle n → TX_READY_O=0 and TX_VALID_O=1 with byte 1 in cycle n+1.
- TX_VALID_O and TX_DATA_O are registered. They are held stable until the handshake; TX_VALID_O never drops without one.
- Handshake on byte 1 in cycle m → byte 2 presented in cycle m+1 with no bubble.
- Final handshake in cycle m → TX_VALID_O=0 and TX_READY_O=1 in cycle m+1.
- Throughput is one request per 2 cycles (single byte) or 3 cycles (two bytes) with TX_READY_I held high.
- RX and TX paths are independent; simultaneous activity on both has no interaction.

## Structure
- uart_pkg holds HEADER, the rx_state_t enum {RX_IDLE, RX_ESC} and the tx_state_t enum {TX_IDLE, TX_FIRST, TX_SECOND}.
- Sub-module uart_cmd_fifo: synchronous FWFT FIFO parameterised by WIDTH (9 here) and DEPTH, with full/empty/count outputs. Reusable elsewhere.
- The top level contains the two FSMs and the output registers.

## Test plan
- Reset, then RX bytes 0x41, 0x01, 0x05 → FIFO holds one data entry 0x41 and one command entry 0x05 (CMD_REC_O=1 on the second); RX_EMPTY_O falls 1 cycle after the first strobe.
- RX 0x01, 0x01, 0x7F → data entries 0x01 and 0x7F, both with CMD_REC_O=0.
- FIFO_DEPTH=8: send 9 plain bytes with no reads → 8 stored, one RX_OVERFLOW_O pulse 1 cycle after the 9th strobe. Then strobe RX_VALID_I and assert READ_I in the same cycle while full → count stays 8.
- WRITE_I with SEND_COMMAND_I=1, COMMAND_I=0x23, TX_READY_I toggled randomly → exact sequence 0x01, 0x23, each byte held until its handshake; TX_READY_O returns 1 cycle after the last handshake.
- WRITE_I with data 0x01, then with data 0x55, TX_READY_I=1 → output stream 0x01, 0x01, 0x55 with the cycle timing above.
- Assert RST_I while in RX_ESC and while TX_SECOND is pending → all outputs at reset values the next cycle. A following RX byte 0x05 is stored as data, not as a command.
